burst_timing_gen: RTL
=====================

BURST_TIMING_GEN -- requirements
Module: burst_timing_gen

Interface
REQ-001 SHALL have port hb0_gtwiz_userclk_tx_usrclk2_int, input, 1 bit: TX user clock; the single clock, all logic on its rising edge.
REQ-002 SHALL have port hb0_gtwiz_reset_tx_datapath_int, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port preamble_length_vio_int, input, 32 bits: preamble cycles per burst.
REQ-004 SHALL have port burst_length_vio_int, input, 32 bits: payload cycles per burst.
REQ-005 SHALL have port burst_period_vio_int, input, 32 bits: cycles per burst period; 0 disables bursting.
REQ-006 SHALL have port error_accumulator_clear, input, 1 bit: clears the statistics counters.
REQ-007 SHALL have port burst_en, output, 1 bit: high during preamble or payload.
REQ-008 SHALL have port preamble_active, output, 1 bit: high during preamble cycles.
REQ-009 SHALL have port payload_active, output, 1 bit: high during payload cycles.
REQ-010 SHALL have port burst_start, output, 1 bit: one-cycle pulse on the first cycle of each period.
REQ-011 SHALL have port burst_count, output, 32 bits: completed periods (statistics build only).
REQ-012 SHALL have port cfg_truncate_count, output, 16 bits: periods in which preamble plus payload exceeded the period (statistics build only).

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, PAYLOAD and GAP, with 32-bit period counter p and shadow registers pre_s, len_s and per_s.
REQ-014 SHALL, in IDLE, load the shadows from the inputs on every cycle, and in the cycle after per_s != 0 SHALL enter the first phase with p = 0.
REQ-015 SHALL select the first phase as PREAMBLE if pre_s > 0, else PAYLOAD if len_s > 0, else GAP.
REQ-016 SHALL set phase at counter value p to: PREAMBLE if p < pre_s; PAYLOAD if pre_s <= p < pre_s + len_s; GAP otherwise.
REQ-017 SHALL compute pre_s + len_s at 33-bit width so the sum does not overflow.
REQ-018 SHALL, when p == per_s - 1, wrap p to 0 on the next cycle, reload all shadows from the inputs, and select the new phase per REQ-015.
REQ-019 SHALL, on a wrap where the reloaded per_s == 0, enter IDLE with every phase output low.
REQ-020 SHALL hold the shadow values constant within a period, so input changes mid-period take effect only at the next wrap.
REQ-021 SHALL truncate any phase still active at the period end; the wrap takes priority.
REQ-022 SHALL give a period of 1 a single-cycle period on every cycle, with burst_start held high continuously.
REQ-023 SHALL register all outputs and decode them from the current state, with no combinational path from any input to any output.
REQ-024 SHALL assert burst_start in the first cycle of every period, including the first period after IDLE.

Reset
REQ-025 SHALL, while reset is high, force IDLE and clear p, the shadows and every output to 0, including burst_count and cfg_truncate_count.
REQ-026 SHALL, when reset is asserted mid-burst, drop burst_en on the next clock edge with no partial-period completion.
REQ-027 SHALL start the first period no earlier than 2 cycles after reset deasserts: one IDLE load cycle, then the first phase.

Configuration
REQ-028 SHALL, when macro BURST_TIMING_STATS_EN is defined, increment burst_count at each wrap, with 32-bit wrap-around.
REQ-029 SHALL, when BURST_TIMING_STATS_EN is defined, increment cfg_truncate_count at the start of any period where pre_s + len_s > per_s, saturating at 0xFFFF.
REQ-030 SHALL, when BURST_TIMING_STATS_EN is defined, clear both counters synchronously on error_accumulator_clear; if clear coincides with an increment, clear wins.
REQ-031 SHALL, when BURST_TIMING_STATS_EN is undefined, tie burst_count and cfg_truncate_count to 0, ignore error_accumulator_clear, and instantiate no counter logic.

Verification
REQ-032 SHALL cover this case: pre=4, len=10, per=20 → per period, preamble_active high 4 cycles, payload_active 10, gap 6; burst_start every 20 cycles.
REQ-033 SHALL cover this case: pre=0, len=5, per=8 → PREAMBLE never entered, payload 5 cycles, gap 3.
REQ-034 SHALL cover this case: pre=6, len=10, per=12 → payload truncated to 6 cycles, no gap, and cfg_truncate_count increments each period (stats build).
REQ-035 SHALL cover this case: change len from 10 to 3 at p=7 → current period unchanged, next period uses 3.
REQ-036 SHALL cover this case: set per=0 mid-period → current period completes, then IDLE with outputs low; restoring per=20 restarts with a burst_start pulse.
REQ-037 SHALL cover this case: reset at p=5 during payload → all outputs 0 on the next edge; burst_count=0; restart after 2 cycles.

Source files
------------

// File: rtl/burst_timing_gen.sv
// burst_timing_gen: per-period preamble/payload/gap burst timing with registered phase outputs.
// Define BURST_TIMING_STATS_EN to build the burst_count / cfg_truncate_count statistics.
module burst_timing_gen (
  input  logic        hb0_gtwiz_userclk_tx_usrclk2_int,
  input  logic        hb0_gtwiz_reset_tx_datapath_int,
  input  logic [31:0] preamble_length_vio_int,
  input  logic [31:0] burst_length_vio_int,
  input  logic [31:0] burst_period_vio_int,
  input  logic        error_accumulator_clear,
  output logic        burst_en,
  output logic        preamble_active,
  output logic        payload_active,
  output logic        burst_start,
  output logic [31:0] burst_count,
  output logic [15:0] cfg_truncate_count
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;
  state_t st_q, st_d;
  logic [31:0] p_q, p_d, pre_q, pre_d, len_q, len_d, per_q, per_d;
  logic en_q, pre_act_q, pay_act_q, start_q, start_d, wrap, new_per, trunc;
  logic clk, rst;
  assign clk = hb0_gtwiz_userclk_tx_usrclk2_int;
  assign rst = hb0_gtwiz_reset_tx_datapath_int;
  function automatic state_t phase(input logic [31:0] p, input logic [31:0] pre, input logic [31:0] len);
    return (p < pre) ? PREAMBLE : ({1'b0, p} < {1'b0, pre} + {1'b0, len}) ? PAYLOAD : GAP;
  endfunction
  always_comb begin
    st_d    = st_q;
    p_d     = p_q;
    pre_d   = pre_q;
    len_d   = len_q;
    per_d   = per_q;
    start_d = 1'b0;
    wrap    = 1'b0;
    new_per = 1'b0;
    if (st_q == IDLE) begin
      if (per_q != 32'd0) begin
        st_d    = phase(32'd0, pre_q, len_q);
        p_d     = 32'd0;
        start_d = 1'b1;
        new_per = 1'b1;
      end else begin
        pre_d = preamble_length_vio_int;
        len_d = burst_length_vio_int;
        per_d = burst_period_vio_int;
      end
    end else if (p_q == per_q - 32'd1) begin
      wrap    = 1'b1;
      p_d     = 32'd0;
      pre_d   = preamble_length_vio_int;
      len_d   = burst_length_vio_int;
      per_d   = burst_period_vio_int;
      new_per = burst_period_vio_int != 32'd0;
      start_d = new_per;
      st_d    = new_per ? phase(32'd0, pre_d, len_d) : IDLE;
    end else begin
      p_d  = p_q + 32'd1;
      st_d = phase(p_d, pre_q, len_q);
    end
    trunc = ({1'b0, pre_d} + {1'b0, len_d}) > {1'b0, per_d};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= IDLE;
      p_q       <= '0;
      pre_q     <= '0;
      len_q     <= '0;
      per_q     <= '0;
      en_q      <= 1'b0;
      pre_act_q <= 1'b0;
      pay_act_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      p_q       <= p_d;
      pre_q     <= pre_d;
      len_q     <= len_d;
      per_q     <= per_d;
      en_q      <= (st_d == PREAMBLE) || (st_d == PAYLOAD);
      pre_act_q <= st_d == PREAMBLE;
      pay_act_q <= st_d == PAYLOAD;
      start_q   <= start_d;
    end
  end
  assign burst_en        = en_q;
  assign preamble_active = pre_act_q;
  assign payload_active  = pay_act_q;
  assign burst_start     = start_q;
`ifdef BURST_TIMING_STATS_EN
  logic [31:0] bc_q;
  logic [15:0] tc_q;
  always_ff @(posedge clk) begin
    if (rst || error_accumulator_clear) begin
      bc_q <= '0;
      tc_q <= '0;
    end else begin
      if (wrap) bc_q <= bc_q + 32'd1;
      if (new_per && trunc && tc_q != 16'hFFFF) tc_q <= tc_q + 16'd1;
    end
  end
  assign burst_count        = bc_q;
  assign cfg_truncate_count = tc_q;
`else
  logic unused_stats;
  assign unused_stats       = error_accumulator_clear ^ wrap ^ new_per ^ trunc;
  assign burst_count        = '0;
  assign cfg_truncate_count = '0;
`endif
endmodule
